// File: rtl/psum_scatter_accum.sv
// Scatter-accumulate of PE product beats into an out_size x out_size
// partial-sum map, with a raster-order drain that self-clears the map.
module psum_scatter_accum #(
  parameter int col_length  = 8,
  parameter int word_length = 8,
  parameter int lanes       = 16,
  parameter int out_size    = 7,
  parameter int acc_width   = 24
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [2*word_length*lanes-1:0]       data_in,
  input  logic [col_length*lanes-1:0]          data_in_cols,
  input  logic [col_length*lanes-1:0]          data_in_rows,
  input  logic                                 flush,
  output logic                                 busy,
  output logic                                 out_valid,
  output logic signed [acc_width-1:0]          out_data,
  output logic [col_length-1:0]                out_row,
  output logic [col_length-1:0]                out_col,
  output logic                                 out_last
);

  localparam int          PW    = 2 * word_length;
  localparam int unsigned MAP_N = out_size * out_size;
  localparam int          AW    = (MAP_N > 1) ? $clog2(MAP_N) : 1;
  localparam int          LW    = (lanes > 1) ? $clog2(lanes) : 1;

  localparam logic [col_length-1:0] COORD_LIM = col_length'(out_size);
  localparam logic [col_length-1:0] COORD_TOP = col_length'(out_size - 1);
  localparam logic [AW-1:0]         OUT_SZ_A  = AW'(out_size);
  localparam logic [AW-1:0]         IDX_LAST  = AW'(MAP_N - 1);
  localparam logic [LW-1:0]         LANE_LAST = LW'(lanes - 1);

  localparam logic signed [acc_width:0] SUM_MAX = {2'b00, {(acc_width-1){1'b1}}};
  localparam logic signed [acc_width:0] SUM_MIN = {2'b11, {(acc_width-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  state_t                         r_state;
  state_t                         w_next;
  logic [PW*lanes-1:0]            r_beat_data;
  logic [col_length*lanes-1:0]    r_beat_rows;
  logic [col_length*lanes-1:0]    r_beat_cols;
  logic [LW-1:0]                  r_lane;
  logic [AW-1:0]                  r_idx;
  logic [col_length-1:0]          r_drow;
  logic [col_length-1:0]          r_dcol;
  logic                           r_flush_pending;
  logic signed [acc_width-1:0]    r_map [MAP_N];

  logic                           w_accept;
  logic                           w_lane_last;
  logic                           w_drain_last;
  logic signed [PW-1:0]           w_prod;
  logic signed [col_length-1:0]   w_row;
  logic signed [col_length-1:0]   w_col;
  logic                           w_in_range;
  logic [AW-1:0]                  w_addr;
  logic signed [acc_width:0]      w_sum;
  logic signed [acc_width-1:0]    w_sat;

  assign w_accept     = (r_state == S_IDLE) && in_valid;
  assign w_lane_last  = (r_lane == LANE_LAST);
  assign w_drain_last = (r_idx == IDX_LAST);

  // in_ready is gated by rst so it reads 0 for the whole reset interval
  assign in_ready = rst && (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE) || r_flush_pending;

  // Select the current lane, range-check its coordinates, form the saturated sum
  always_comb begin
    w_prod = r_beat_data[r_lane*PW +: PW];
    w_row  = r_beat_rows[r_lane*col_length +: col_length];
    w_col  = r_beat_cols[r_lane*col_length +: col_length];
    // sign bit rules out negatives so the upper-bound test can be unsigned
    w_in_range = !w_row[col_length-1] && !w_col[col_length-1] &&
                 (unsigned'(w_row) < COORD_LIM) && (unsigned'(w_col) < COORD_LIM);
    w_addr = AW'(unsigned'(w_row)) * OUT_SZ_A + AW'(unsigned'(w_col));
    w_sum  = (acc_width+1)'(r_map[w_addr]) + (acc_width+1)'(w_prod);
    if (w_sum > SUM_MAX) begin
      w_sat = SUM_MAX[acc_width-1:0];
    end else if (w_sum < SUM_MIN) begin
      w_sat = SUM_MIN[acc_width-1:0];
    end else begin
      w_sat = w_sum[acc_width-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; an incoming beat wins over a pending flush
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid)             w_next = S_ACCUM;
        else if (r_flush_pending) w_next = S_DRAIN;
      end
      S_ACCUM: if (w_lane_last)  w_next = S_IDLE;
      S_DRAIN: if (w_drain_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Beat capture and lane sequencing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat_data <= '0;
      r_beat_rows <= '0;
      r_beat_cols <= '0;
      r_lane      <= '0;
    end else if (w_accept) begin
      r_beat_data <= data_in;
      r_beat_rows <= data_in_rows;
      r_beat_cols <= data_in_cols;
      r_lane      <= '0;
    end else if (r_state == S_ACCUM) begin
      r_lane <= r_lane + LW'(1);
    end
  end

  // Raster counters for the drain, parked at zero whenever idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx  <= '0;
      r_drow <= '0;
      r_dcol <= '0;
    end else if (r_state == S_DRAIN) begin
      r_idx <= r_idx + AW'(1);
      if (r_dcol == COORD_TOP) begin
        r_dcol <= '0;
        r_drow <= r_drow + col_length'(1);
      end else begin
        r_dcol <= r_dcol + col_length'(1);
      end
    end else begin
      r_idx  <= '0;
      r_drow <= '0;
      r_dcol <= '0;
    end
  end

  // Flush request latch; completion of a drain clears it even if flush is still high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   r_flush_pending <= 1'b0;
    else if ((r_state == S_DRAIN) && w_drain_last) r_flush_pending <= 1'b0;
    else if (flush)                             r_flush_pending <= 1'b1;
  end

  // Partial-sum map: accumulate one lane per cycle, clear entries as they drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < MAP_N; i++) r_map[i] <= '0;
    end else if ((r_state == S_ACCUM) && w_in_range) begin
      r_map[w_addr] <= w_sat;
    end else if (r_state == S_DRAIN) begin
      r_map[r_idx] <= '0;
    end
  end

  // Registered drain outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else if (r_state == S_DRAIN) begin
      out_valid <= 1'b1;
      out_data  <= r_map[r_idx];
      out_row   <= r_drow;
      out_col   <= r_dcol;
      out_last  <= w_drain_last;
    end else begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_scatter_accum.sv
// Randomized bench for psum_scatter_accum against an array-based map model.
module tb_psum_scatter_accum;

  localparam int LANES = 16;
  localparam int PW    = 16;
  localparam int CL    = 8;
  localparam int OS    = 7;
  localparam int N     = OS * OS;
  localparam int ACCW  = 24;
  localparam longint SMAX = 64'sd8388607;
  localparam longint SMIN = -64'sd8388608;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [PW*LANES-1:0]    data_in;
  logic [CL*LANES-1:0]    data_in_cols;
  logic [CL*LANES-1:0]    data_in_rows;
  logic                   flush;
  logic                   busy;
  logic                   out_valid;
  logic signed [ACCW-1:0] out_data;
  logic [CL-1:0]          out_row;
  logic [CL-1:0]          out_col;
  logic                   out_last;

  int n_tests = 0;
  int n_fail  = 0;

  longint               m_map [N];
  logic signed [PW-1:0] b_val [LANES];
  int                   b_row [LANES];
  int                   b_col [LANES];

  psum_scatter_accum #(
    .col_length (CL),
    .word_length(PW/2),
    .lanes      (LANES),
    .out_size   (OS),
    .acc_width  (ACCW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .data_in_cols(data_in_cols),
    .data_in_rows(data_in_rows),
    .flush       (flush),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_row     (out_row),
    .out_col     (out_col),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    for (int i = 0; i < N; i++) m_map[i] = 0;
  endfunction

  // Reference: each in-range lane adds into its map cell, in lane order, clamped
  function automatic void model_beat();
    for (int k = 0; k < LANES; k++) begin
      if (b_row[k] >= 0 && b_row[k] < OS && b_col[k] >= 0 && b_col[k] < OS) begin
        int     a = b_row[k] * OS + b_col[k];
        longint s = m_map[a] + longint'(b_val[k]);
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        m_map[a] = s;
      end
    end
  endfunction

  function automatic void fill_beat(input int val, input int row, input int col);
    for (int k = 0; k < LANES; k++) begin
      b_val[k] = PW'(val);
      b_row[k] = row;
      b_col[k] = col;
    end
  endfunction

  function automatic void rand_beat(input int lo, input int hi);
    for (int k = 0; k < LANES; k++) begin
      b_val[k] = PW'($urandom);
      b_row[k] = int'($urandom_range(hi - lo)) + lo;
      b_col[k] = int'($urandom_range(hi - lo)) + lo;
    end
  endfunction

  task automatic send_beat();
    int g = 0;
    for (int k = 0; k < LANES; k++) begin
      data_in[k*PW +: PW]      = b_val[k];
      data_in_rows[k*CL +: CL] = CL'(b_row[k]);
      data_in_cols[k*CL +: CL] = CL'(b_col[k]);
    end
    @(negedge clk);
    in_valid = 1'b1;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: got in_ready=%0b expected 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_beat();
  endtask

  task automatic wait_idle(output int low);
    low = 0;
    @(negedge clk);
    while (!in_ready && low < 100) begin
      low++;
      @(negedge clk);
    end
  endtask

  // Optionally pulses flush, then checks the full 49-entry drain against the model
  task automatic flush_drain(input bit pulse, input string tag, input int exp_lat);
    int g = 0;
    if (pulse) begin
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
    end else begin
      @(negedge clk);
    end
    while (!out_valid && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!out_valid) begin
      n_tests++; n_fail++;
      $display("FAIL %s_drain_timeout: got out_valid=0 expected 1", tag);
      return;
    end
    if (exp_lat >= 0) begin
      n_tests++;
      if (g !== exp_lat) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d expected %0d", tag, g, exp_lat);
      end
    end
    for (int i = 0; i < N; i++) begin
      logic signed [ACCW-1:0] e_d;
      logic [CL-1:0]          e_r;
      logic [CL-1:0]          e_c;
      logic                   e_l;
      e_d = ACCW'(m_map[i]);
      e_r = CL'(i / OS);
      e_c = CL'(i % OS);
      e_l = (i == N - 1);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== e_d || out_row !== e_r ||
          out_col !== e_c || out_last !== e_l) begin
        n_fail++;
        $display("FAIL %s_entry%0d: got v=%0b d=%0d r=%0d c=%0d l=%0b expected v=1 d=%0d r=%0d c=%0d l=%0b",
                 tag, i, out_valid, out_data, out_row, out_col, out_last, e_d, e_r, e_c, e_l);
      end
      @(negedge clk);
    end
    n_tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_after_drain: got v=%0b l=%0b busy=%0b expected 0 0 0",
               tag, out_valid, out_last, busy);
    end
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    data_in = '0; data_in_rows = '0; data_in_cols = '0;
    model_clear();
    repeat (3) @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got in_ready=%0b busy=%0b expected 0 0", in_ready, busy);
    end
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_row !== '0 || out_col !== '0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: got v=%0b d=%0d r=%0d c=%0d l=%0b expected all 0",
               out_valid, out_data, out_row, out_col, out_last);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %0b expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    int low;
    fill_beat(0, 0, 0);
    b_val[0] = 16'sd100; b_row[0] = 2; b_col[0] = 3;
    send_beat();
    wait_idle(low);
    flush_drain(1'b1, "single", 2);
  endtask

  task automatic test_collision();
    int low;
    fill_beat(-5, 1, 1);
    send_beat();
    wait_idle(low);
    n_tests++;
    if (low !== LANES) begin
      n_fail++;
      $display("FAIL collision_ready_low: got %0d expected %0d", low, LANES);
    end
    flush_drain(1'b1, "collision", 2);
  endtask

  task automatic test_drop();
    int low;
    fill_beat(0, 0, 0);
    b_val[0] = 16'sd50; b_row[0] = -1;  b_col[0] = 0;
    b_val[1] = 16'sd50; b_row[1] = 0;   b_col[1] = 7;
    b_val[2] = 16'sd50; b_row[2] = 7;   b_col[2] = 0;
    b_val[3] = 16'sd50; b_row[3] = -128; b_col[3] = 127;
    b_val[4] = 16'sd50; b_row[4] = 3;   b_col[4] = -1;
    send_beat();
    wait_idle(low);
    flush_drain(1'b1, "drop", 2);
  endtask

  task automatic test_random();
    int low;
    for (int b = 0; b < 8; b++) begin
      rand_beat(-1, 8);
      send_beat();
      wait_idle(low);
    end
    flush_drain(1'b1, "random", 2);
  endtask

  task automatic test_saturation();
    int low;
    fill_beat(32767, 0, 0);
    for (int b = 0; b < 400; b++) begin
      send_beat();
      wait_idle(low);
    end
    flush_drain(1'b1, "sat_pos", 2);
    fill_beat(-32768, 0, 0);
    for (int b = 0; b < 400; b++) begin
      send_beat();
      wait_idle(low);
    end
    flush_drain(1'b1, "sat_neg", 2);
  endtask

  task automatic test_flush_mid_accum();
    rand_beat(0, 6);
    send_beat();
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_accum_state: got ready=%0b v=%0b busy=%0b expected 0 0 1",
               in_ready, out_valid, busy);
    end
    flush_drain(1'b0, "mid_accum", -1);
    flush_drain(1'b1, "back_to_back", 2);
  endtask

  task automatic test_priority();
    rand_beat(0, 6);
    flush = 1'b1;
    send_beat();
    flush = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL priority_state: got busy=%0b v=%0b ready=%0b expected 1 0 0",
               busy, out_valid, in_ready);
    end
    flush_drain(1'b0, "priority", -1);
  endtask

  task automatic test_reset_mid_drain();
    int low;
    int g = 0;
    rand_beat(0, 6);
    send_beat();
    wait_idle(low);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    while (!out_valid && g < 300) begin
      @(negedge clk);
      g++;
    end
    repeat (20) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || out_row !== CL'(20 / OS) || out_col !== CL'(20 % OS)) begin
      n_fail++;
      $display("FAIL pre_reset_entry20: got v=%0b r=%0d c=%0d expected 1 %0d %0d",
               out_valid, out_row, out_col, 20 / OS, 20 % OS);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_row !== '0 || out_col !== '0 ||
        out_last !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_drain_reset: got v=%0b d=%0d r=%0d c=%0d l=%0b ready=%0b busy=%0b expected all 0",
               out_valid, out_data, out_row, out_col, out_last, in_ready, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_clear();
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_ready: got %0b expected 1", in_ready);
    end
    flush_drain(1'b1, "post_reset", 2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_collision();
    test_drop();
    test_random();
    test_saturation();
    test_flush_mid_accum();
    test_priority();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_scatter_accum.md
# psum_scatter_accum

Accumulates the 16-lane product beats that the sparse-convolution PE emits, each product tagged with a signed output row/column, into an on-chip partial-sum map of `out_size`×`out_size` entries. It sits directly downstream of the PE. Partial sums from successive beats and input channels add into the same map. On a flush request the map is streamed out in raster order and self-cleared, ready for the next output channel.

## Interface
- `col_length`, 8: width of each signed row/col coordinate.
- `word_length`, 8: PE operand width; each product is `2*word_length` bits, signed.
- `lanes`, 16: products per input beat.
- `out_size`, 7: output map dimension; valid coordinates are 0..`out_size`-1.
- `acc_width`, 24: signed accumulator width per map entry.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset. Asynchronous assert, active-low (0 = reset).
- `in_valid` in 1: beat present; driven from PE `out_valid`.
- `in_ready` out 1: beat is accepted on a cycle where `in_valid & in_ready`.
- `data_in` in `2*word_length*lanes`: lane k product is at `[(k+1)*2*word_length-1 -: 2*word_length]`.
- `data_in_cols` in `col_length*lanes`: lane k column is at `[(k+1)*col_length-1 -: col_length]`, signed.
- `data_in_rows` in `col_length*lanes`: lane k row, same packing as the columns, signed.
- `flush` in 1: request to drain the map; one-cycle pulse or level.
- `busy` out 1: high in ACCUM or DRAIN, or while a flush is pending.
- `out_valid` out 1: a drained entry is present.
- `out_data` out `acc_width`: entry value, signed.
- `out_row` out `col_length`: row of the drained entry.
- `out_col` out `col_length`: column of the drained entry.
- `out_last` out 1: marks the final entry of the drain, at (`out_size`-1, `out_size`-1).

## Operation
- The FSM has three states: IDLE, ACCUM, DRAIN.
- **IDLE**
  - `in_ready`=1.
  - If `in_valid`: capture all lanes into the beat register, set lane counter to 0, go to ACCUM.
  - Else if `flush_pending`: go to DRAIN with the raster index at 0.
  - An accepted beat has priority over a pending flush.
- **ACCUM**
  - `in_ready`=0.
  - Processes one lane per cycle, in lane order 0..`lanes`-1.
  - A lane with row or column < 0 or ≥ `out_size` is dropped; the map is unchanged for that lane.
  - Otherwise: `map[row][col]` ← sat(`map[row][col]` + sign-extended product).
  - Two lanes that hit the same entry are summed correctly because the lanes are processed serially.
  - After the last lane, go to IDLE.
- **DRAIN**
  - `in_ready`=0.
  - Each cycle, present the entry at the current raster index (row-major) on the output registers.
  - That entry is written to 0 in the same cycle.
  - After `out_size*out_size` entries, go to IDLE and clear `flush_pending`.
- **`flush_pending`**
  - Set on any cycle `flush`=1 in any state.
  - Cleared only when a drain completes.
  - A `flush` asserted during DRAIN is absorbed, not queued a second time.
- **Saturation**
  - The sum clamps to +2^(`acc_width`-1)-1 or -2^(`acc_width`-1).
  - There is no wrap-around.
- **Reset** (`rst`=0, at any time, including mid-ACCUM or mid-DRAIN):
  - Every map entry becomes 0; the partially processed beat is discarded and is not resumed.
  - State → IDLE; `flush_pending`=0.
  - Outputs: `in_ready`=0 while reset is asserted, then 1 in IDLE; `busy`=0.
  - `out_valid`, `out_data`, `out_row`, `out_col`, `out_last` are all 0.

## Timing
- A beat accepted at edge T updates lane k at edge T+1+k.
- `in_ready` is low for edges T+1..T+`lanes` and returns high after edge T+`lanes` (ACCUM→IDLE), so a new beat can be taken at edge T+`lanes`+1.
- Maximum throughput is one beat per `lanes`+1 cycles. Upstream must hold `in_valid` and its data until accepted.
- **Drain timing**
  - The flush is taken in IDLE at edge F.
  - Outputs are registered; `out_valid` is high for exactly `out_size*out_size` consecutive cycles, beginning after edge F+1.
  - `out_last` is high on the final cycle only; `out_valid` drops the cycle after.
  - There is no output backpressure.
- **Read-after-update**
  - A drain started immediately after an ACCUM reflects every lane of that beat.
  - A beat accepted immediately after a drain accumulates onto an all-zero map.
- **Simultaneous `in_valid` and pending flush in IDLE:** the beat is taken first; the drain starts at the next IDLE cycle in which `in_valid`=0.

## Test plan
- **Single beat, single entry:** lane 0 = +100 at (2,3), other lanes 0 at (0,0); flush. Expect 49 outputs: entry 17 (row 2, col 3) = 100, all others 0. `out_last` is set with (6,6).
- **Same-entry collisions:** all 16 lanes = -5 at (1,1). Expect entry (1,1) = -80 after the drain; `in_ready` is low for exactly 16 cycles.
- **Out-of-range drop:** lanes at row -1, col 7, and row 7, each with value 50. Expect the map to stay all-zero.
- **Saturation:** 400 beats of 16 lanes × +32767 at (0,0). Expect the entry to clamp to 8388607 with no wrap. Repeat with -32768 and expect -8388608.
- **Flush during ACCUM / back-to-back:**
  - Pulse `flush` mid-beat. Expect the drain to start only after ACCUM ends and to include that beat.
  - A second drain immediately after yields all zeros.
- **Reset mid-DRAIN:** assert `rst`=0 at output entry 20. Expect all outputs 0 and the map cleared. After release, a flush drains 49 zeros.
